// File: rtl/mat_mult_2x2_acc_pipe.sv
// 2x2 matrix multiplier [w x; y z] = [a b; c d] * [e f; g h], 3-stage valid/ready pipeline
// with per-beat signed/unsigned mode and per-beat saturating accumulate into the output registers.
module mat_mult_2x2_acc_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  input  logic              is_signed,
  input  logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  w,
  output logic [ACC_W-1:0]  x,
  output logic [ACC_W-1:0]  y,
  output logic [ACC_W-1:0]  z,
  output logic              sat
);

  localparam int EW = DATA_W + 1;
  localparam int PW = 2 * DATA_W + 2;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic adv;

  logic [DATA_W-1:0] in_op [8];
  logic              s1_valid, s1_signed, s1_acc;
  logic [DATA_W-1:0] s1_op [8];

  logic signed [EW-1:0] ext_op [8];
  logic signed [PW-1:0] prod_c [8];
  logic                 s2_valid, s2_signed, s2_acc;
  logic signed [PW-1:0] s2_prod [8];

  logic signed [ACC_W-1:0] sum_c [4];
  logic [ACC_W:0]          acc_t [4];
  logic [ACC_W-1:0]        nxt_c [4];
  logic [3:0]              clamp_c;
  logic [ACC_W-1:0]        acc_q [4];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign in_op[0] = a;
  assign in_op[1] = b;
  assign in_op[2] = c;
  assign in_op[3] = d;
  assign in_op[4] = e;
  assign in_op[5] = f;
  assign in_op[6] = g;
  assign in_op[7] = h;

  assign w = acc_q[0];
  assign x = acc_q[1];
  assign y = acc_q[2];
  assign z = acc_q[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_acc    <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) s1_op[i] <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_signed <= is_signed;
      s1_acc    <= acc_en;
      for (int unsigned i = 0; i < 8; i++) s1_op[i] <= in_op[i];
    end
  end

  // Products ordered ae, bg, af, bh, ce, dg, cf, dh so element k sums pair (2k, 2k+1).
  always_comb begin
    for (int unsigned i = 0; i < 8; i++)
      ext_op[i] = $signed({s1_signed & s1_op[i][DATA_W-1], s1_op[i]});
    prod_c[0] = PW'(ext_op[0]) * PW'(ext_op[4]);
    prod_c[1] = PW'(ext_op[1]) * PW'(ext_op[6]);
    prod_c[2] = PW'(ext_op[0]) * PW'(ext_op[5]);
    prod_c[3] = PW'(ext_op[1]) * PW'(ext_op[7]);
    prod_c[4] = PW'(ext_op[2]) * PW'(ext_op[4]);
    prod_c[5] = PW'(ext_op[3]) * PW'(ext_op[6]);
    prod_c[6] = PW'(ext_op[2]) * PW'(ext_op[5]);
    prod_c[7] = PW'(ext_op[3]) * PW'(ext_op[7]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_signed <= 1'b0;
      s2_acc    <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) s2_prod[i] <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_signed <= s1_signed;
      s2_acc    <= s1_acc;
      for (int unsigned i = 0; i < 8; i++) s2_prod[i] <= prod_c[i];
    end
  end

  // One extra bit on the add exposes signed overflow (top two bits differ) or unsigned carry.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      sum_c[k]   = ACC_W'(s2_prod[2*k]) + ACC_W'(s2_prod[2*k+1]);
      nxt_c[k]   = sum_c[k];
      clamp_c[k] = 1'b0;
      acc_t[k]   = '0;
      if (s2_acc) begin
        if (s2_signed) begin
          acc_t[k] = {acc_q[k][ACC_W-1], acc_q[k]} + {sum_c[k][ACC_W-1], sum_c[k]};
          if (acc_t[k][ACC_W] != acc_t[k][ACC_W-1]) begin
            clamp_c[k] = 1'b1;
            nxt_c[k]   = acc_t[k][ACC_W] ? SMIN : SMAX;
          end else begin
            nxt_c[k] = acc_t[k][ACC_W-1:0];
          end
        end else begin
          acc_t[k] = {1'b0, acc_q[k]} + {1'b0, sum_c[k]};
          if (acc_t[k][ACC_W]) begin
            clamp_c[k] = 1'b1;
            nxt_c[k]   = '1;
          end else begin
            nxt_c[k] = acc_t[k][ACC_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) acc_q[k] <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        sat <= |clamp_c;
        for (int unsigned k = 0; k < 4; k++) acc_q[k] <= nxt_c[k];
      end
    end
  end

endmodule

// File: tb/tb_mat_mult_2x2_acc_pipe.sv
// Bench for mat_mult_2x2_acc_pipe: arithmetic reference model with an ordered expectation queue,
// per-cycle handshake/stall checks, and hand-computed literal results for directed vectors.
module tb_mat_mult_2x2_acc_pipe;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam longint SMAX = (longint'(1) <<< 39) - 1;
  localparam longint SMIN = -(longint'(1) <<< 39);
  localparam longint UMAX = (longint'(1) <<< 40) - 1;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, is_signed, acc_en, out_valid, out_ready, sat;
  logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
  logic [ACC_W-1:0]  w, x, y, z;

  typedef struct packed {
    logic [3:0][ACC_W-1:0] el;
    logic                  sat;
  } res_t;

  int checks = 0;
  int failures = 0;
  res_t exp_q[$];
  res_t out_log[$];
  logic [3:0][ACC_W-1:0] m_acc = '0;

  mat_mult_2x2_acc_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .is_signed(is_signed), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
    .w(w), .x(x), .y(y), .z(z), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic longint ext(input logic [DATA_W-1:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Matrix product plus optional clamped accumulation, in plain integer arithmetic.
  function automatic res_t model_beat(input logic [7:0][DATA_W-1:0] op, input logic sgn, input logic acc);
    longint s[4];
    longint av, t;
    res_t r;
    r.sat = 1'b0;
    s[0] = ext(op[0], sgn) * ext(op[4], sgn) + ext(op[1], sgn) * ext(op[6], sgn);
    s[1] = ext(op[0], sgn) * ext(op[5], sgn) + ext(op[1], sgn) * ext(op[7], sgn);
    s[2] = ext(op[2], sgn) * ext(op[4], sgn) + ext(op[3], sgn) * ext(op[6], sgn);
    s[3] = ext(op[2], sgn) * ext(op[5], sgn) + ext(op[3], sgn) * ext(op[7], sgn);
    for (int k = 0; k < 4; k++) begin
      t = s[k];
      if (acc) begin
        av = sgn ? longint'($signed(m_acc[k])) : longint'(m_acc[k]);
        t = av + s[k];
        if (sgn && t > SMAX) begin t = SMAX; r.sat = 1'b1; end
        else if (sgn && t < SMIN) begin t = SMIN; r.sat = 1'b1; end
        else if (!sgn && t > UMAX) begin t = UMAX; r.sat = 1'b1; end
      end
      r.el[k] = t[ACC_W-1:0];
      m_acc[k] = r.el[k];
    end
    return r;
  endfunction

  logic [3:0][ACC_W-1:0] prev_el;
  logic prev_sat;
  logic prev_hold = 1'b0;

  always @(negedge clk) begin
    res_t r, act;
    if (reset) begin
      exp_q.delete();
      m_acc = '0;
      prev_hold = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_hold) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'({w, x, y, z} != prev_el), 64'd0);
        check("stall_sat", 64'(sat), 64'(prev_sat));
      end
      if (in_valid && in_ready)
        exp_q.push_back(model_beat({h, g, f, e, d, c, b, a}, is_signed, acc_en));
      if (out_valid && out_ready) begin
        act.el[0] = w; act.el[1] = x; act.el[2] = y; act.el[3] = z; act.sat = sat;
        out_log.push_back(act);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          r = exp_q.pop_front();
          check("model_w", 64'(w), 64'(r.el[0]));
          check("model_x", 64'(x), 64'(r.el[1]));
          check("model_y", 64'(y), 64'(r.el[2]));
          check("model_z", 64'(z), 64'(r.el[3]));
          check("model_sat", 64'(sat), 64'(r.sat));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_el   = {w, x, y, z};
      prev_sat  = sat;
    end
  end

  function automatic logic [7:0][DATA_W-1:0] mk(input logic [DATA_W-1:0] va, vb, vc, vd, ve, vf, vg, vh);
    return {vh, vg, vf, ve, vd, vc, vb, va};
  endfunction

  task automatic drive(input logic [7:0][DATA_W-1:0] op, input logic sgn, input logic acc);
    a = op[0]; b = op[1]; c = op[2]; d = op[3];
    e = op[4]; f = op[5]; g = op[6]; h = op[7];
    is_signed = sgn; acc_en = acc; in_valid = 1'b1;
  endtask

  task automatic send(input logic [7:0][DATA_W-1:0] op, input logic sgn, input logic acc);
    int n = 0;
    logic took;
    drive(op, sgn, acc);
    do begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!took && n < 50);
    if (!took) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic log_chk(input int idx, input logic [ACC_W-1:0] ew, ex, ey, ez, input logic es);
    if (idx >= out_log.size()) begin
      check($sformatf("log_present_%0d", idx), 64'd0, 64'd1);
    end else begin
      check($sformatf("lit_w_%0d", idx), 64'(out_log[idx].el[0]), 64'(ew));
      check($sformatf("lit_x_%0d", idx), 64'(out_log[idx].el[1]), 64'(ex));
      check($sformatf("lit_y_%0d", idx), 64'(out_log[idx].el[2]), 64'(ey));
      check($sformatf("lit_z_%0d", idx), 64'(out_log[idx].el[3]), 64'(ez));
      check($sformatf("lit_sat_%0d", idx), 64'(out_log[idx].sat), 64'(es));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [7:0][DATA_W-1:0] op_ident, op_t1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_wxyz", 64'(|{w, x, y, z}), 64'd0);
    check("reset_sat", 64'(sat), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Basic product and 3-edge latency from the edge after the beat is presented.
    out_log.delete();
    op_t1 = mk(1, 2, 3, 4, 5, 6, 7, 8);
    @(posedge clk); #1;
    drive(op_t1, 1'b1, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) in_valid = 1'b0;
    end while (!out_valid && cyc < 10);
    check("latency_edges", 64'(cyc), 64'd3);
    drain();
    log_chk(0, 40'd19, 40'd22, 40'd43, 40'd50, 1'b0);

    // Extreme operands, signed and unsigned.
    out_log.delete();
    send(mk(16'h8000, 0, 0, 0, 16'h8000, 0, 0, 0), 1'b1, 1'b0);
    send(mk(16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0), 1'b0, 1'b0);
    send(mk(16'hFFFF, 0, 0, 0, 16'h0002, 0, 0, 0), 1'b1, 1'b0);
    drain();
    log_chk(0, 40'd1073741824, 40'd0, 40'd0, 40'd0, 1'b0);
    log_chk(1, 40'd4294836225, 40'd0, 40'd0, 40'd0, 1'b0);
    log_chk(2, 40'hFF_FFFF_FFFE, 40'd0, 40'd0, 40'd0, 1'b0);

    // Back-to-back identity accumulation.
    out_log.delete();
    op_ident = mk(1, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) send(op_ident, 1'b1, i != 0);
    drain();
    for (int i = 0; i < 4; i++)
      log_chk(i, 40'(i + 1), 40'd0, 40'd0, 40'(i + 1), 1'b0);

    // Streaming with a 5-cycle consumer stall mid-stream.
    out_log.delete();
    fork
      for (int i = 0; i < 6; i++) send(mk(16'(i + 1), 0, 0, 0, 2, 0, 0, 0), 1'b1, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      log_chk(i, 40'(2 * (i + 1)), 40'd0, 40'd0, 40'd0, 1'b0);

    // Signed positive saturation, then a fresh load clears sat.
    out_log.delete();
    for (int i = 0; i < 257; i++)
      send(mk(16'h8000, 16'h8000, 0, 0, 16'h8000, 0, 16'h8000, 0), 1'b1, i != 0);
    send(mk(1, 0, 0, 0, 1, 0, 0, 0), 1'b1, 1'b0);
    drain();
    log_chk(254, 40'd547608330240, 40'd0, 40'd0, 40'd0, 1'b0);
    log_chk(255, 40'd549755813887, 40'd0, 40'd0, 40'd0, 1'b1);
    log_chk(256, 40'd549755813887, 40'd0, 40'd0, 40'd0, 1'b1);
    log_chk(257, 40'd1, 40'd0, 40'd0, 40'd0, 1'b0);

    // Signed negative saturation.
    out_log.delete();
    for (int i = 0; i < 258; i++)
      send(mk(16'h8000, 16'h8000, 0, 0, 16'h7FFF, 0, 16'h7FFF, 0), 1'b1, i != 0);
    drain();
    log_chk(255, 40'd549772591104, 40'd0, 40'd0, 40'd0, 1'b0);
    log_chk(256, 40'h80_0000_0000, 40'd0, 40'd0, 40'd0, 1'b1);

    // Unsigned saturation.
    out_log.delete();
    for (int i = 0; i < 129; i++)
      send(mk(16'hFFFF, 16'hFFFF, 0, 0, 16'hFFFF, 0, 16'hFFFF, 0), 1'b0, i != 0);
    drain();
    log_chk(127, 40'd1099478073600, 40'd0, 40'd0, 40'd0, 1'b0);
    log_chk(128, 40'd1099511627775, 40'd0, 40'd0, 40'd0, 1'b1);

    // Asynchronous reset with beats in flight.
    out_log.delete();
    for (int i = 0; i < 3; i++) send(op_t1, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_wxyz", 64'(|{w, x, y, z}), 64'd0);
    check("async_rst_sat", 64'(sat), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);
    out_log.delete();
    send(op_ident, 1'b1, 1'b1);
    drain();
    log_chk(0, 40'd1, 40'd0, 40'd0, 40'd1, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
